// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit and its return-address stack.
package pc_pkg;

  localparam int unsigned PC_INCR        = 4;
  localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC    = 32'h0000_0080;

  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_HOLD,
    NPC_BR,
    NPC_J,
    NPC_JR,
    NPC_EXC
  } npc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr_c;
  logic [CNT_W-1:0]  count;
  logic              replace_c;

  assign top_ptr_c = wr_ptr - PTR_W'(1);
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(RAS_DEPTH));
  assign top       = empty ? '0 : mem[top_ptr_c];
  // push+pop on a non-empty stack rewrites the top in place
  assign replace_c = push && pop && !empty;

  always_ff @(posedge clk) begin
    if (en && !clear && push) begin
      if (replace_c) mem[top_ptr_c] <= push_data;
      else           mem[wr_ptr]    <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (push && !replace_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!full) count <= count + CNT_W'(1);
      end else if (pop && !push && !empty) begin
        wr_ptr <= top_ptr_c;
        count  <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised next-PC select, redirect alignment check and a
// return-address stack for jr $ra prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              exception,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              ras_push,
  input  logic [ADDR_W-1:0] ras_push_data,
  input  logic              ras_pop,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign_err
);

  npc_sel_e          sel_c;
  logic [ADDR_W-1:0] raw_tgt_c;
  logic [ADDR_W-1:0] pc_next_c;
  logic              misalign_c;
  logic              ras_en_c;

  assign pc_plus4 = pc_out + ADDR_W'(PC_INCR);

  // Priority select: a redirect always wins over a stall
  always_comb begin
    sel_c     = NPC_SEQ;
    raw_tgt_c = '0;
    if (exception) begin
      sel_c = NPC_EXC;
    end else if (jr) begin
      sel_c     = NPC_JR;
      raw_tgt_c = jr_target;
    end else if (jump) begin
      sel_c     = NPC_J;
      raw_tgt_c = jump_target;
    end else if (branch_taken) begin
      sel_c     = NPC_BR;
      raw_tgt_c = branch_target;
    end else if (!pc_write) begin
      sel_c = NPC_HOLD;
    end
  end

  always_comb begin
    pc_next_c  = pc_plus4;
    misalign_c = 1'b0;
    case (sel_c)
      NPC_EXC:  pc_next_c = EXC_VEC;
      NPC_HOLD: pc_next_c = pc_out;
      NPC_JR, NPC_J, NPC_BR: begin
        pc_next_c  = {raw_tgt_c[ADDR_W-1:2], 2'b00};
        misalign_c = (raw_tgt_c[1:0] != 2'b00);
      end
      default:  pc_next_c = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out       <= RESET_VEC;
      misalign_err <= 1'b0;
    end else begin
      pc_out       <= pc_next_c;
      misalign_err <= misalign_c;
    end
  end

  // A stalled instruction must not touch the stack twice
  assign ras_en_c = pc_write || (sel_c != NPC_SEQ && sel_c != NPC_HOLD);

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .en       (ras_en_c),
    .clear    (exception),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(ras_push_data),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined MIPS datapath, successor to the single-register PC.
- Holds the fetch address and computes next-PC internally: sequential increment, branch, jump, register jump and exception vector.
- Honours the hazard-unit stall, checks alignment of redirect targets, and keeps a return-address stack (RAS) so the ID stage can predict `jr $ra` targets.
- Sits between the hazard unit / ID-EX redirect logic and the instruction memory address port.

Parameters:
- ADDR_W, 32, PC and target width in bits (>= 8).
- RESET_VEC, 32'h0000_0000, value loaded into PC on reset.
- EXC_VEC, 32'h0000_0080, exception handler address.
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_write  in  1  hazard enable; 0 = hold PC (stall).
- exception  in  1  load EXC_VEC.
- branch_taken  in  1  load branch_target.
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  load jump_target (j/jal).
- jump_target  in  ADDR_W  jump destination.
- jr  in  1  load jr_target.
- jr_target  in  ADDR_W  register-jump destination.
- ras_push  in  1  push return address (jal decoded).
- ras_push_data  in  ADDR_W  return address to push.
- ras_pop  in  1  pop RAS (jr $ra decoded).
- pc_out  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc_out + 4, combinational.
- ras_top  out  ADDR_W  top-of-stack, combinational; 0 when empty.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- misalign_err  out  1  one-cycle pulse: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset (async, any time, including mid-redirect):
  - pc_out = RESET_VEC, RAS count = 0, misalign_err = 0.
  - ras_empty = 1, ras_full = 0, ras_top = 0.
- Next-PC priority at each rising edge, highest first:
  1. exception → EXC_VEC
  2. jr → jr_target
  3. jump → jump_target
  4. branch_taken → branch_target
  5. pc_write = 0 → hold pc_out
  6. otherwise → pc_out + 4
- Redirects (items 1–4) take effect even when pc_write = 0, because a flush overrides a stall.
- Latency: pc_out changes one edge after the selecting inputs are sampled. pc_plus4 and ras_top have zero latency.
- Alignment on jr/jump/branch loads:
  - The loaded value has bits[1:0] forced to 0.
  - If the raw target had bits[1:0] != 0, misalign_err = 1 for exactly the next cycle, otherwise 0.
  - EXC_VEC is never checked.
- Arithmetic: pc_out + 4 is modulo 2^ADDR_W. Wrap-around from all-ones-minus-3 gives 0, with no flag.
- RAS operation, on the rising edge, gated by pc_write = 1 or any redirect:
  - Push writes ras_push_data to top, count + 1.
  - Push when full overwrites the oldest entry (circular); count stays RAS_DEPTH.
  - Pop removes top, count − 1. Pop when empty is ignored.
  - Simultaneous push and pop replace the top entry; count unchanged. When empty this acts as a plain push.
- exception clears the RAS (count = 0) on the same edge, regardless of push/pop.
- While stalled with no redirect, push and pop are ignored so a held instruction is not double-counted.

Decomposition:
- Shared package pc_pkg:
  - next-PC select enum: NPC_SEQ, NPC_HOLD, NPC_BR, NPC_J, NPC_JR, NPC_EXC.
  - PC_INCR = 4.
  - default RESET_VEC and EXC_VEC constants.
- One sub-module, pc_ras: circular stack (RAS_DEPTH × ADDR_W, pointer, count), same clk/reset.
- pc_unit itself holds the priority mux, PC register and alignment check.

Test Plan:
- Assert reset for 2 cycles, release, pc_write = 1 for 3 edges → pc_out 0x0, 0x4, 0x8, 0xC; ras_empty = 1.
- At pc_out = 0x10 hold pc_write = 0 for 2 edges, then release → pc_out 0x10, 0x10, then 0x14.
- With pc_write = 0, drive branch_taken = 1 and branch_target = 0x200 → pc_out = 0x200 next edge. Then drive jump = 1 and exception = 1 together → pc_out = 0x80.
- jr = 1 with jr_target = 0x1237 → pc_out = 0x1234, misalign_err = 1 for one cycle then 0.
- Push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 with RAS_DEPTH = 4:
  - ras_full = 1, ras_top = 0xE0.
  - Pop 4 times → tops 0xD0, 0xC0, 0xB0, then ras_empty = 1.
  - A 5th pop leaves the stack empty, ras_top = 0.
- Assert reset asynchronously mid-cycle with RAS holding 2 entries and pc_out = 0x300 → pc_out = 0x0 immediately, ras_empty = 1, without waiting for a clk edge.
